// File: rtl/io_channel_bank_if.sv
// Core channel bus plus host RX/TX handshakes for io_channel_bank.
// Valid/ready: a word moves on a rising clock edge where valid and ready are both 1; the sender holds data stable while valid=1 and ready=0.
interface io_channel_bank_if;
    logic        IO_write_en;
    logic [3:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [3:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [14:0] rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [14:0] tx_data;

    modport master (
        output IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
        output rx_valid, rx_data, tx_ready,
        input  IO_read_data, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
        input  rx_valid, rx_data, tx_ready,
        output IO_read_data, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/io_channel_bank.sv
// Sixteen-channel IO bank: output registers, synchronized inputs, status,
// a single-word TX holding register and a host-to-core RX FIFO.
module io_channel_bank #(
    parameter int RX_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    io_channel_bank_if.slave bus,
    output logic [119:0]  out_chan,
    input  logic [74:0]   ext_in
);
    localparam int         PW    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [3:0] DEPTH = 4'(RX_DEPTH);

    logic [7:0][14:0] out_q;
    logic [4:0][14:0] ext_s1, ext_s2;
    logic [14:0]      rx_mem [RX_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [3:0]       rx_count;
    logic             rx_full, rx_nonempty, push, pop;
    logic             tx_valid_q, tx_ovf;
    logic [14:0]      tx_data_q;
    logic             wr_ch13, wr_ch14, wr_ch15, tx_accept, tx_drop;
    logic [2:0]       ext_idx;

    assign wr_ch13 = bus.IO_write_en && (bus.IO_write_sel == 4'd13);
    assign wr_ch14 = bus.IO_write_en && (bus.IO_write_sel == 4'd14);
    assign wr_ch15 = bus.IO_write_en && (bus.IO_write_sel == 4'd15);

    // Full/empty come from the registered count only, so rx_ready never
    // depends on a same-cycle pop.
    assign rx_full     = (rx_count == DEPTH);
    assign rx_nonempty = (rx_count != 4'd0);
    assign push        = bus.rx_valid && !rx_full;
    assign pop         = wr_ch15 && rx_nonempty;

    assign tx_accept = wr_ch14 && (!tx_valid_q || bus.tx_ready);
    assign tx_drop   = wr_ch14 && tx_valid_q && !bus.tx_ready;

    assign bus.rx_ready = !rx_full;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign out_chan     = out_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= '0;
            ext_s1 <= '0;
            ext_s2 <= '0;
        end else begin
            ext_s1 <= ext_in;
            ext_s2 <= ext_s1;
            if (bus.IO_write_en && !bus.IO_write_sel[3])
                out_q[bus.IO_write_sel[2:0]] <= bus.IO_write_data;
        end
    end

    // Storage needs no reset: the head is only read while the count is nonzero.
    always_ff @(posedge clock) begin
        if (push) rx_mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   rx_count <= rx_count + 4'd1;
                2'b01:   rx_count <= rx_count - 4'd1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_ovf     <= 1'b0;
        end else begin
            if (tx_accept) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= bus.IO_write_data;
            end else if (tx_valid_q && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            // Setting on a dropped word takes priority over a status-write clear.
            if (tx_drop)      tx_ovf <= 1'b1;
            else if (wr_ch13) tx_ovf <= 1'b0;
        end
    end

    assign ext_idx = 3'(bus.IO_read_sel - 4'd8);

    always_comb begin
        bus.IO_read_data = '0;
        case (bus.IO_read_sel)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                bus.IO_read_data = out_q[bus.IO_read_sel[2:0]];
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                bus.IO_read_data = ext_s2[ext_idx];
            4'd13:
                bus.IO_read_data = {7'd0, tx_ovf, tx_valid_q, rx_count, rx_full, rx_nonempty};
            4'd14:
                bus.IO_read_data = tx_data_q;
            default:
                bus.IO_read_data = rx_nonempty ? rx_mem[rd_ptr] : 15'd0;
        endcase
    end
endmodule

// File: tb/tb_io_channel_bank.sv
// Directed bench for io_channel_bank: output regs, input synchronizers,
// RX FIFO fill/drain, TX overflow, and mid-cycle asynchronous reset.
module tb_io_channel_bank;
    logic          clock = 1'b0;
    logic          reset_n;
    logic [119:0]  out_chan;
    logic [74:0]   ext_in;
    int            total = 0;
    int            bad = 0;

    io_channel_bank_if bus();

    io_channel_bank #(.RX_DEPTH(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_chan (out_chan),
        .ext_in   (ext_in)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] sel, input string tag, input logic [14:0] exp);
        bus.IO_read_sel = sel;
        #1;
        chk(tag, 128'(bus.IO_read_data), 128'(exp));
    endtask

    task automatic wr(input logic [3:0] sel, input logic [14:0] data);
        bus.IO_write_en   = 1'b1;
        bus.IO_write_sel  = sel;
        bus.IO_write_data = data;
    endtask

    task automatic wr_off;
        bus.IO_write_en   = 1'b0;
        bus.IO_write_sel  = '0;
        bus.IO_write_data = '0;
    endtask

    initial begin
        reset_n           = 1'b0;
        ext_in            = '0;
        bus.IO_read_sel   = '0;
        bus.rx_valid      = 1'b0;
        bus.rx_data       = '0;
        bus.tx_ready      = 1'b0;
        wr_off();
        tick();
        tick();
        chk("rst_out_chan", 128'(out_chan), 128'd0);
        chk("rst_rx_ready", 128'(bus.rx_ready), 128'd1);
        chk("rst_tx_valid", 128'(bus.tx_valid), 128'd0);
        rd(4'd13, "rst_status", 15'h0000);
        reset_n = 1'b1;
        tick();

        // Output register: same-cycle read returns old value.
        wr(4'd3, 15'o12345);
        rd(4'd3, "ch3_same_cycle", 15'd0);
        tick();
        wr_off();
        rd(4'd3, "ch3_next_cycle", 15'o12345);
        chk("out_chan_ch3", 128'(out_chan), 128'(120'(15'o12345) << 45));

        // Synchronized input: two-edge lag.
        ext_in = 75'(15'h5A5A) << 15;
        rd(4'd9, "ch9_before_edge", 15'd0);
        tick();
        rd(4'd9, "ch9_after_edge1", 15'd0);
        tick();
        rd(4'd9, "ch9_after_edge2", 15'h5A5A);
        wr(4'd9, 15'h0001);
        tick();
        wr_off();
        rd(4'd9, "ch9_write_ignored", 15'h5A5A);

        // Fill RX FIFO with 1..4.
        for (int k = 1; k <= 4; k++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 15'(k);
            #1;
            chk("rx_ready_filling", 128'(bus.rx_ready), 128'd1);
            tick();
        end
        chk("rx_ready_full", 128'(bus.rx_ready), 128'd0);
        rd(4'd13, "status_full", 15'h0013);
        bus.rx_data = 15'd5;
        tick();
        rd(4'd13, "status_5th_rejected", 15'h0013);
        rd(4'd15, "head_1", 15'd1);

        // Full: simultaneous push attempt and pop.
        bus.rx_data = 15'd6;
        wr(4'd15, 15'd0);
        tick();
        bus.rx_valid = 1'b0;
        wr_off();
        rd(4'd13, "status_pop_when_full", 15'h000D);
        rd(4'd15, "head_2", 15'd2);
        chk("rx_ready_after_pop", 128'(bus.rx_ready), 128'd1);
        wr(4'd15, 15'd0);
        tick();
        rd(4'd15, "head_3", 15'd3);
        tick();
        rd(4'd15, "head_4", 15'd4);
        tick();
        rd(4'd15, "head_empty", 15'd0);
        tick();
        wr_off();
        rd(4'd13, "status_empty_after_extra_pop", 15'h0000);
        rd(4'd15, "head_still_empty", 15'd0);

        // Refill two words across the pointer wrap.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 15'h7001;
        tick();
        bus.rx_data  = 15'h7002;
        tick();
        bus.rx_valid = 1'b0;
        rd(4'd15, "head_after_wrap", 15'h7001);
        rd(4'd13, "status_two_words", 15'h0009);

        // TX overflow.
        wr(4'd14, 15'd7);
        tick();
        chk("tx_valid_loaded", 128'(bus.tx_valid), 128'd1);
        rd(4'd14, "ch14_readback", 15'd7);
        wr(4'd14, 15'd9);
        tick();
        wr_off();
        chk("tx_data_held", 128'(bus.tx_data), 128'd7);
        rd(4'd13, "status_overflow", 15'h00C9);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("tx_valid_dropped", 128'(bus.tx_valid), 128'd0);
        rd(4'd13, "status_ovf_sticky", 15'h0089);
        wr(4'd13, 15'h7FFF);
        tick();
        wr_off();
        rd(4'd13, "status_ovf_cleared", 15'h0009);

        // Write accepted while a handshake completes in the same cycle.
        wr(4'd14, 15'h0011);
        tick();
        wr(4'd14, 15'h0022);
        bus.tx_ready = 1'b1;
        tick();
        wr_off();
        bus.tx_ready = 1'b0;
        chk("tx_data_replaced", 128'(bus.tx_data), 128'h22);
        rd(4'd13, "status_no_ovf", 15'h0049);

        // Mid-cycle asynchronous reset with FIFO and TX pending.
        bus.IO_read_sel = 4'd13;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_chan", 128'(out_chan), 128'd0);
        chk("arst_rx_ready", 128'(bus.rx_ready), 128'd1);
        chk("arst_tx_valid", 128'(bus.tx_valid), 128'd0);
        chk("arst_tx_data", 128'(bus.tx_data), 128'd0);
        chk("arst_status", 128'(bus.IO_read_data), 128'd0);
        rd(4'd15, "arst_head", 15'd0);
        rd(4'd9, "arst_sync", 15'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 15'h0033;
        tick();
        tick();
        bus.rx_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        rd(4'd13, "post_reset_status", 15'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
